hyperbus_burst_splitter: RTL and testbench
==========================================

// Module: hyperbus_burst_splitter
// PURPOSE
//  Command-path stage upstream of the HyperBus PHY/transaction engine, downstream of the AXI front-end.
//  Splits each incoming transfer command (start address and length in 16-bit words) into consecutive
//  sub-bursts. No sub-burst exceeds the programmed max burst length, which bounds CS-low time
//  (e.g. 250 words keeps CS below 4 us).
//  Marks the first and last sub-burst so downstream can track AXI response merging.
// PARAMETERS
//  AddrWidth      32  byte address width; address arithmetic is modulo 2**AddrWidth
//  LenWidth       16  width of length fields (encoded as words-1)
//  MaxBurstWidth  16  width of the cfg_max_burst_i register field
// PORTS
//  clk_i          in   1              clock
//  rst_ni         in   1              asynchronous active-low reset
//  cfg_max_burst_i in  MaxBurstWidth  max words per sub-burst; 0 = unlimited
//  in_valid_i     in   1              command valid
//  in_ready_o     out  1              command accepted when valid&ready
//  in_addr_i      in   AddrWidth      start byte address (16-bit aligned; bit 0 ignored, forced 0)
//  in_len_i       in   LenWidth       number of 16-bit words minus one
//  in_write_i     in   1              1 = write, 0 = read
//  out_valid_o    out  1              sub-burst valid
//  out_ready_i    in   1              sub-burst accepted when valid&ready
//  out_addr_o     out  AddrWidth      sub-burst start byte address
//  out_len_o      out  LenWidth       sub-burst words minus one
//  out_write_o    out  1              copy of latched in_write_i
//  out_first_o    out  1              first sub-burst of the command
//  out_last_o     out  1              last sub-burst of the command
//  busy_o         out  1              command in progress (state != IDLE)
// BEHAVIOUR
//  Reset: state=IDLE.
//   - Outputs after reset: out_valid_o=0, in_ready_o=1, busy_o=0; all out_* data fields = 0.
//   - Reset mid-command discards the command with no further output.
//  FSM: IDLE -> SPLIT on in handshake; SPLIT -> IDLE on out handshake with out_last_o=1.
//  in_ready_o = (state==IDLE); no pass-through.
//   - out_valid_o rises exactly 1 cycle after the in handshake.
//   - in_ready_o rises 1 cycle after the last out handshake (1 bubble per command).
//  On accept, latch:
//   - addr = {in_addr_i[AddrWidth-1:1],1'b0}
//   - rem = in_len_i+1 (LenWidth+1 bits)
//   - write flag
//   - max = cfg_max_burst_i
//  cfg_max_burst_i changes while busy are ignored until the next command.
//  chunk = (max==0 || rem<=max) ? rem : max.
//   - out_len_o = chunk-1; out_last_o = (rem==chunk).
//   - out_first_o = 1 only for the first sub-burst.
//  On out handshake with !last:
//   - addr += chunk*2 (wraps modulo 2**AddrWidth)
//   - rem -= chunk
//   - out_valid_o stays 1 (next sub-burst presented the following cycle, no bubble)
//  AXI-style stability: while out_valid_o && !out_ready_i, all out_* fields hold.
//   - out_valid_o never drops without a handshake.
//  in_* inputs are ignored outside IDLE.
//  max > 2**LenWidth behaves as unlimited.
//  Length 1 (in_len_i=0) gives one sub-burst with first=last=1.
// TESTING
//  - Addr 0xA00, len 999, max 250, write=1 -> 4 sub-bursts:
//    addr 0xA00/0xBF4/0xDE8/0xFDC, len 249 each; first on #1, last on #4; out_write_o=1 throughout.
//  - Addr 0xA00, len 1000, max 250 -> 5 sub-bursts; 5th is addr 0x11D0, len 0, last=1.
//  - Addr 0x110, len 4089, max 0 -> single sub-burst: addr 0x110, len 4089, first=last=1.
//  - Addr 0x402, len 2, max 1 with out_ready_i low 3 cycles on each:
//    -> addr 0x402/0x404/0x406, len 0 each; fields stable while stalled.
//  - Addr 0xFFFF_FFFC, len 3, max 2 -> sub-bursts at 0xFFFF_FFFC and 0x0000_0000 (wrap).
//  - Change cfg to 100 mid-command -> chunking unchanged.
//  - Reset during sub-burst #2 -> out_valid_o=0 immediately, in_ready_o=1.
//    Next command starts with first=1.

Source files
------------

// File: rtl/hyperbus_burst_splitter.sv
// Splits a word-length transfer command into consecutive sub-bursts no longer than the latched max.
// One command at a time: in_ready_o only in IDLE, sub-bursts issued back to back, one bubble per command.
module hyperbus_burst_splitter #(
  parameter int AddrWidth     = 32,
  parameter int LenWidth      = 16,
  parameter int MaxBurstWidth = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [MaxBurstWidth-1:0] cfg_max_burst_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [AddrWidth-1:0]     in_addr_i,
  input  logic [LenWidth-1:0]      in_len_i,
  input  logic                     in_write_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [AddrWidth-1:0]     out_addr_o,
  output logic [LenWidth-1:0]      out_len_o,
  output logic                     out_write_o,
  output logic                     out_first_o,
  output logic                     out_last_o,
  output logic                     busy_o
);

  localparam int RemWidth = LenWidth + 1;
  localparam int CmpWidth = (RemWidth > MaxBurstWidth) ? RemWidth : MaxBurstWidth;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SPLIT = 1'b1;

  logic [0:0]               state_q;
  logic [AddrWidth-1:0]     addr_q;
  logic [RemWidth-1:0]      rem_q;
  logic [MaxBurstWidth-1:0] max_q;
  logic                     write_q;
  logic                     first_q;

  logic [CmpWidth-1:0]      rem_ext;
  logic [CmpWidth-1:0]      max_ext;
  logic [RemWidth-1:0]      chunk;
  logic                     last;
  logic                     busy;

  assign rem_ext = CmpWidth'(rem_q);
  assign max_ext = CmpWidth'(max_q);

  // A max larger than any possible remainder never wins the compare, so it acts as unlimited.
  always_comb begin
    chunk = rem_q;
    if (max_q != '0 && rem_ext > max_ext) begin
      chunk = max_ext[RemWidth-1:0];
    end
  end

  assign last = (rem_q == chunk);
  assign busy = (state_q == SPLIT);

  assign in_ready_o  = (state_q == IDLE);
  assign busy_o      = busy;
  assign out_valid_o = busy;
  assign out_addr_o  = busy ? addr_q : '0;
  assign out_len_o   = busy ? LenWidth'(chunk - RemWidth'(1)) : '0;
  assign out_write_o = busy & write_q;
  assign out_first_o = busy & first_q;
  assign out_last_o  = busy & last;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      max_q   <= '0;
      write_q <= 1'b0;
      first_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            state_q <= SPLIT;
            addr_q  <= in_addr_i & ~AddrWidth'(1);
            rem_q   <= RemWidth'(in_len_i) + RemWidth'(1);
            max_q   <= cfg_max_burst_i;
            write_q <= in_write_i;
            first_q <= 1'b1;
          end
        end
        SPLIT: begin
          if (out_ready_i) begin
            first_q <= 1'b0;
            if (last) begin
              state_q <= IDLE;
            end else begin
              addr_q <= addr_q + AddrWidth'({chunk, 1'b0});
              rem_q  <= rem_q - chunk;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hyperbus_burst_splitter.sv
// Directed bench for hyperbus_burst_splitter: hand-computed sub-burst sequences per scenario.
module tb_hyperbus_burst_splitter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] cfg_max_burst = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_addr = '0;
  logic [15:0] in_len = '0;
  logic        in_write = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_addr;
  logic [15:0] out_len;
  logic        out_write;
  logic        out_first;
  logic        out_last;
  logic        busy;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] cap_addr [16];
  logic [15:0] cap_len [16];
  logic        cap_write [16];
  logic        cap_first [16];
  logic        cap_last [16];
  int          cap_cyc [16];
  int          cap_n;
  logic        cap_to;

  always #5 clk = ~clk;

  hyperbus_burst_splitter dut (
    .clk_i(clk), .rst_ni(rst_n), .cfg_max_burst_i(cfg_max_burst),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_addr_i(in_addr),
    .in_len_i(in_len), .in_write_i(in_write),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_addr_o(out_addr),
    .out_len_o(out_len), .out_write_o(out_write), .out_first_o(out_first),
    .out_last_o(out_last), .busy_o(busy)
  );

  // Presents one command for a single cycle; returns 1 ns after the accepting edge.
  task automatic send_cmd(input logic [31:0] a, input logic [15:0] l, input logic w,
                          input logic [15:0] mx);
    in_addr = a; in_len = l; in_write = w; cfg_max_burst = mx; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Records sub-bursts with out_ready held high until the last one is taken.
  task automatic capture(input int budget);
    cap_n = 0; cap_to = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < budget; c++) begin
      if (out_valid) begin
        if (cap_n < 16) begin
          cap_addr[cap_n] = out_addr; cap_len[cap_n] = out_len; cap_write[cap_n] = out_write;
          cap_first[cap_n] = out_first; cap_last[cap_n] = out_last; cap_cyc[cap_n] = c;
        end
        cap_n++;
        if (out_last) begin
          @(posedge clk); #1;
          cap_to = 1'b0;
          break;
        end
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; #12;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", in_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if ({out_addr, out_len, out_write, out_first, out_last} !== 51'd0) begin
      n_fail++; $display("FAIL reset_fields got %h/%h/%b%b%b want zeros", out_addr, out_len, out_write, out_first, out_last); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_idle_valid got %b want 0", out_valid); end
    send_cmd(32'hA00, 16'd999, 1'b1, 16'd250);
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency got %b want 1", out_valid); end
    n_cmp++; if (busy !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_busy got %b/%b want 1/0", busy, in_ready); end
    capture(40);
    n_cmp++; if (cap_to !== 1'b0 || cap_n != 4) begin n_fail++; $display("FAIL basic_count got %0d to=%b want 4", cap_n, cap_to); end
    for (int i = 0; i < 4 && i < cap_n; i++) begin
      n_cmp++;
      if (cap_addr[i] !== 32'hA00 + 32'(i * 500) || cap_len[i] !== 16'd249 || cap_write[i] !== 1'b1 ||
          cap_first[i] !== (i == 0) || cap_last[i] !== (i == 3) || cap_cyc[i] != i) begin
        n_fail++;
        $display("FAIL basic_sub%0d got a=%h l=%0d w%b f%b l%b c%0d want a=%h l=249 w1 f%b l%b c%0d", i,
                 cap_addr[i], cap_len[i], cap_write[i], cap_first[i], cap_last[i], cap_cyc[i],
                 32'hA00 + 32'(i * 500), i == 0, i == 3, i);
      end
    end
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_bubble got rdy=%b vld=%b want 1/0", in_ready, out_valid); end
  endtask

  task automatic test_tail;
    send_cmd(32'hA00, 16'd1000, 1'b0, 16'd250);
    capture(40);
    n_cmp++; if (cap_to !== 1'b0 || cap_n != 5) begin n_fail++; $display("FAIL tail_count got %0d want 5", cap_n); end
    n_cmp++; if (cap_len[3] !== 16'd249 || cap_last[3] !== 1'b0 || cap_write[3] !== 1'b0) begin
      n_fail++; $display("FAIL tail_sub3 got l=%0d last=%b w=%b want 249/0/0", cap_len[3], cap_last[3], cap_write[3]); end
    n_cmp++; if (cap_addr[4] !== 32'h11D0 || cap_len[4] !== 16'd0 || cap_last[4] !== 1'b1 || cap_first[4] !== 1'b0) begin
      n_fail++; $display("FAIL tail_sub4 got a=%h l=%0d f%b l%b want 11d0/0/0/1", cap_addr[4], cap_len[4], cap_first[4], cap_last[4]); end
  endtask

  task automatic test_unlimited;
    send_cmd(32'h111, 16'd4089, 1'b1, 16'd0);
    capture(10);
    n_cmp++; if (cap_to !== 1'b0 || cap_n != 1) begin n_fail++; $display("FAIL unlim_count got %0d want 1", cap_n); end
    n_cmp++; if (cap_addr[0] !== 32'h110 || cap_len[0] !== 16'd4089 || cap_first[0] !== 1'b1 || cap_last[0] !== 1'b1) begin
      n_fail++; $display("FAIL unlim_sub got a=%h l=%0d f%b l%b want 110/4089/1/1", cap_addr[0], cap_len[0], cap_first[0], cap_last[0]); end
  endtask

  task automatic test_exact_and_single;
    send_cmd(32'h1000, 16'd499, 1'b0, 16'd250);
    capture(10);
    n_cmp++; if (cap_n != 2 || cap_addr[1] !== 32'h11F4 || cap_len[1] !== 16'd249 || cap_last[1] !== 1'b1 || cap_last[0] !== 1'b0) begin
      n_fail++; $display("FAIL exact_split got n=%0d a=%h l=%0d want 2/11f4/249", cap_n, cap_addr[1], cap_len[1]); end
    send_cmd(32'h37, 16'd0, 1'b1, 16'd5);
    capture(10);
    n_cmp++; if (cap_n != 1 || cap_addr[0] !== 32'h36 || cap_len[0] !== 16'd0 || cap_first[0] !== 1'b1 || cap_last[0] !== 1'b1) begin
      n_fail++; $display("FAIL single_word got n=%0d a=%h l=%0d f%b l%b want 1/36/0/1/1", cap_n, cap_addr[0], cap_len[0], cap_first[0], cap_last[0]); end
  endtask

  task automatic test_stall;
    logic [31:0] s_addr;
    logic [15:0] s_len;
    logic        s_first, s_last;
    send_cmd(32'h402, 16'd2, 1'b0, 16'd1);
    for (int k = 0; k < 3; k++) begin
      out_ready = 1'b0;
      s_addr = out_addr; s_len = out_len; s_first = out_first; s_last = out_last;
      n_cmp++; if (out_valid !== 1'b1 || s_addr !== 32'h402 + 32'(2 * k) || s_len !== 16'd0 ||
                   s_first !== (k == 0) || s_last !== (k == 2)) begin
        n_fail++; $display("FAIL stall_sub%0d got v%b a=%h l=%0d f%b l%b want a=%h", k, out_valid, s_addr, s_len, s_first, s_last, 32'h402 + 32'(2 * k)); end
      repeat (3) begin
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b1 || out_addr !== s_addr || out_len !== s_len ||
                     out_first !== s_first || out_last !== s_last) begin
          n_fail++; $display("FAIL stall_hold%0d got v%b a=%h l=%0d want v1 a=%h l=%0d", k, out_valid, out_addr, out_len, s_addr, s_len); end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_end got v%b r%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_wrap;
    send_cmd(32'hFFFF_FFFC, 16'd3, 1'b1, 16'd2);
    capture(10);
    n_cmp++; if (cap_n != 2 || cap_addr[0] !== 32'hFFFF_FFFC || cap_addr[1] !== 32'h0 ||
                 cap_len[0] !== 16'd1 || cap_len[1] !== 16'd1 || cap_last[1] !== 1'b1) begin
      n_fail++; $display("FAIL wrap got n=%0d a0=%h a1=%h l0=%0d l1=%0d want 2/fffffffc/0/1/1", cap_n, cap_addr[0], cap_addr[1], cap_len[0], cap_len[1]); end
  endtask

  task automatic test_cfg_change;
    send_cmd(32'hA00, 16'd999, 1'b1, 16'd250);
    cfg_max_burst = 16'd100;
    // A second command held valid while busy must be ignored.
    in_valid = 1'b1; in_addr = 32'h5550; in_len = 16'd7; in_write = 1'b0;
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL cfg_inready got %b want 0", in_ready); end
    capture(40);
    in_valid = 1'b0;
    n_cmp++; if (cap_n != 4) begin n_fail++; $display("FAIL cfg_count got %0d want 4", cap_n); end
    for (int i = 0; i < 4 && i < cap_n; i++) begin
      n_cmp++;
      if (cap_addr[i] !== 32'hA00 + 32'(i * 500) || cap_len[i] !== 16'd249 || cap_write[i] !== 1'b1) begin
        n_fail++; $display("FAIL cfg_sub%0d got a=%h l=%0d w%b want a=%h l=249 w1", i, cap_addr[i], cap_len[i], cap_write[i], 32'hA00 + 32'(i * 500)); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    send_cmd(32'hA00, 16'd999, 1'b1, 16'd250);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++; if (out_addr !== 32'hBF4 || out_first !== 1'b0) begin n_fail++; $display("FAIL rmid_sub2 got a=%h f%b want bf4/0", out_addr, out_first); end
    rst_n = 1'b0; #1;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rmid_abort got v%b r%b b%b want 0/1/0", out_valid, in_ready, busy); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_quiet got %b want 0", out_valid); end
    send_cmd(32'h20, 16'd0, 1'b0, 16'd0);
    capture(10);
    n_cmp++; if (cap_n != 1 || cap_addr[0] !== 32'h20 || cap_first[0] !== 1'b1 || cap_last[0] !== 1'b1) begin
      n_fail++; $display("FAIL rmid_next got n=%0d a=%h f%b l%b want 1/20/1/1", cap_n, cap_addr[0], cap_first[0], cap_last[0]); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_tail;
    test_unlimited;
    test_exact_and_single;
    test_stall;
    test_wrap;
    test_cfg_change;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
